// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset main controller.
package multicycle_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_FUNCT = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b100;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_dst;
    logic       reg_wr;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_ORI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J: op_supported = 1'b1;
      default:                                                op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_out_decode.sv
// Combinational state/op -> datapath control word decoder.
module multicycle_out_decode
  import multicycle_pkg::*;
(
  input  state_e          i_state,
  input  logic [OP_W-1:0] i_op,
  input  logic            i_mem_ready,
  output ctrl_t           o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_rd    = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        // PC and IR only update when the instruction word actually arrives
        o_ctrl.pc_wr     = i_mem_ready;
        o_ctrl.ir_wr     = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b  = SRCB_IMM_SH;
        o_ctrl.ext_op     = 1'b1;
        o_ctrl.illegal_op = ~op_supported(i_op);
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.ext_op    = 1'b1;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_rd = 1'b1;
        o_ctrl.iord   = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_wr     = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_wr = 1'b1;
        o_ctrl.iord   = 1'b1;
      end
      S_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_wr  = 1'b1;
        o_ctrl.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = SRCB_RT;
        o_ctrl.alu_op     = ALU_SUB;
        o_ctrl.pc_wr_cond = 1'b1;
        o_ctrl.pc_source  = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_wr     = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      S_I_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        if (i_op == OP_ORI) begin
          o_ctrl.alu_op = ALU_OR;
          o_ctrl.ext_op = 1'b0;
        end else begin
          o_ctrl.alu_op = ALU_ADD;
          o_ctrl.ext_op = 1'b1;
        end
      end
      S_I_WB: begin
        o_ctrl.reg_wr = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller: state register, next-state logic, reset gating
// of control outputs and retired-instruction counter.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_W-1:0]      op,
  input  logic                 mem_ready,
  output logic                 PCWr,
  output logic                 PCWrCond,
  output logic                 IorD,
  output logic                 MemRd,
  output logic                 MemWr,
  output logic                 IRWr,
  output logic                 RegDst,
  output logic                 RegWr,
  output logic                 MemtoReg,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 ExtOp,
  output logic [2:0]           ALUop,
  output logic [1:0]           PCSource,
  output logic                 illegal_op,
  output logic [STATE_W-1:0]   state,
  output logic [CNT_W-1:0]     instr_cnt
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_retire;
  logic [CNT_W-1:0] r_instr_cnt;
  ctrl_t            w_ctrl;
  ctrl_t            w_ctrl_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Next state and retire strobe; retire fires on the edge leaving a final step.
  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH:    if (mem_ready) w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:     w_state_nxt = S_MEM_ADDR;
          OP_RTYPE:         w_state_nxt = S_R_EXEC;
          OP_ORI, OP_ADDIU: w_state_nxt = S_I_EXEC;
          OP_BEQ:           w_state_nxt = S_BRANCH;
          OP_J:             w_state_nxt = S_JUMP;
          default:          w_state_nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR: w_state_nxt = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) w_state_nxt = S_MEM_WB;
      S_MEM_WR: begin
        if (mem_ready) begin
          w_state_nxt = S_FETCH;
          w_retire    = 1'b1;
        end
      end
      S_R_EXEC:   w_state_nxt = S_R_WB;
      S_I_EXEC:   w_state_nxt = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: begin
        w_state_nxt = S_FETCH;
        w_retire    = 1'b1;
      end
      default:    w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instr_cnt <= '0;
    else if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
  end

  multicycle_out_decode u_out_decode (
    .i_state     (r_state),
    .i_op        (op),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // No datapath write may leak out while reset is held.
  assign w_ctrl_g = rst_n ? w_ctrl : '0;

  assign PCWr       = w_ctrl_g.pc_wr;
  assign PCWrCond   = w_ctrl_g.pc_wr_cond;
  assign IorD       = w_ctrl_g.iord;
  assign MemRd      = w_ctrl_g.mem_rd;
  assign MemWr      = w_ctrl_g.mem_wr;
  assign IRWr       = w_ctrl_g.ir_wr;
  assign RegDst     = w_ctrl_g.reg_dst;
  assign RegWr      = w_ctrl_g.reg_wr;
  assign MemtoReg   = w_ctrl_g.mem_to_reg;
  assign ALUSrcA    = w_ctrl_g.alu_src_a;
  assign ALUSrcB    = w_ctrl_g.alu_src_b;
  assign ExtOp      = w_ctrl_g.ext_op;
  assign ALUop      = w_ctrl_g.alu_op;
  assign PCSource   = w_ctrl_g.pc_source;
  assign illegal_op = w_ctrl_g.illegal_op;
  assign state      = r_state;
  assign instr_cnt  = r_instr_cnt;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for the multi-cycle main controller.
module tb_multicycle_control;

  localparam int unsigned CW = 4;

  // {PCWr,PCWrCond,IorD,MemRd,MemWr,IRWr, RegDst,RegWr,MemtoReg,ALUSrcA, ALUSrcB, ExtOp, ALUop, PCSource, illegal_op}
  localparam logic [18:0] C_ZERO    = 19'b000000_0000_00_0_000_00_0;
  localparam logic [18:0] C_FETCH_W = 19'b000100_0000_01_0_000_00_0;
  localparam logic [18:0] C_FETCH_R = 19'b100101_0000_01_0_000_00_0;
  localparam logic [18:0] C_DEC     = 19'b000000_0000_11_1_000_00_0;
  localparam logic [18:0] C_DEC_ILL = 19'b000000_0000_11_1_000_00_1;
  localparam logic [18:0] C_MADDR   = 19'b000000_0001_10_1_000_00_0;
  localparam logic [18:0] C_MRD     = 19'b001100_0000_00_0_000_00_0;
  localparam logic [18:0] C_MWB     = 19'b000000_0110_00_0_000_00_0;
  localparam logic [18:0] C_MWR     = 19'b001010_0000_00_0_000_00_0;
  localparam logic [18:0] C_REXEC   = 19'b000000_0001_00_0_001_00_0;
  localparam logic [18:0] C_RWB     = 19'b000000_1100_00_0_000_00_0;
  localparam logic [18:0] C_BRANCH  = 19'b010000_0001_00_0_100_01_0;
  localparam logic [18:0] C_JUMP    = 19'b100000_0000_00_0_000_10_0;
  localparam logic [18:0] C_IEX_ORI = 19'b000000_0001_10_0_010_00_0;
  localparam logic [18:0] C_IEX_ADD = 19'b000000_0001_10_1_000_00_0;
  localparam logic [18:0] C_IWB     = 19'b000000_0100_00_0_000_00_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ORI = 6'b001101;
  localparam logic [5:0] ADDIU = 6'b001001, BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;

  typedef struct {
    logic [5:0]    op;
    logic          mr;
    logic [3:0]    st;
    logic [18:0]   ctrl;
    logic [CW-1:0] cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    op;
  logic          mem_ready;
  logic          PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, RegWr, MemtoReg, ALUSrcA, ExtOp, illegal_op;
  logic [1:0]    ALUSrcB, PCSource;
  logic [2:0]    ALUop;
  logic [3:0]    state;
  logic [CW-1:0] instr_cnt;
  logic [18:0]   ctrl_w;

  int n_checks = 0;
  int n_fail   = 0;
  int pcwr_seen, memwr_seen, regwr_seen;
  vec_t vecs[$];

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr),
    .IRWr(IRWr), .RegDst(RegDst), .RegWr(RegWr), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALUop(ALUop), .PCSource(PCSource),
    .illegal_op(illegal_op), .state(state), .instr_cnt(instr_cnt)
  );

  assign ctrl_w = {PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, RegWr, MemtoReg,
                   ALUSrcA, ALUSrcB, ExtOp, ALUop, PCSource, illegal_op};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle, check pre-edge outputs, then advance past the edge.
  task automatic step(input logic [5:0] o, input logic mr, input logic [3:0] st,
                      input logic [18:0] c, input logic [CW-1:0] cnt, input string tag);
    op = o;
    mem_ready = mr;
    #1;
    check({tag, " state"}, 32'(state), 32'(st));
    check({tag, " ctrl"}, 32'(ctrl_w), 32'(c));
    check({tag, " cnt"}, 32'(instr_cnt), 32'(cnt));
    pcwr_seen  += int'(PCWr);
    memwr_seen += int'(MemWr);
    regwr_seen += int'(RegWr);
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [5:0] o, input logic mr, input logic [3:0] st,
                              input logic [18:0] c, input logic [CW-1:0] cnt);
    vec_t v;
    v.op = o; v.mr = mr; v.st = st; v.ctrl = c; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    // mem_ready held high throughout: also shows it is ignored outside memory states
    add(LW,    1'b1, 4'd0,  C_FETCH_R, 4'd0);
    add(LW,    1'b1, 4'd1,  C_DEC,     4'd0);
    add(LW,    1'b1, 4'd2,  C_MADDR,   4'd0);
    add(LW,    1'b1, 4'd3,  C_MRD,     4'd0);
    add(LW,    1'b1, 4'd4,  C_MWB,     4'd0);
    add(RT,    1'b1, 4'd0,  C_FETCH_R, 4'd1);
    add(RT,    1'b1, 4'd1,  C_DEC,     4'd1);
    add(RT,    1'b1, 4'd6,  C_REXEC,   4'd1);
    add(RT,    1'b1, 4'd7,  C_RWB,     4'd1);
    add(ORI,   1'b1, 4'd0,  C_FETCH_R, 4'd2);
    add(ORI,   1'b1, 4'd1,  C_DEC,     4'd2);
    add(ORI,   1'b1, 4'd10, C_IEX_ORI, 4'd2);
    add(ORI,   1'b1, 4'd11, C_IWB,     4'd2);
    add(ADDIU, 1'b1, 4'd0,  C_FETCH_R, 4'd3);
    add(ADDIU, 1'b1, 4'd1,  C_DEC,     4'd3);
    add(ADDIU, 1'b1, 4'd10, C_IEX_ADD, 4'd3);
    add(ADDIU, 1'b1, 4'd11, C_IWB,     4'd3);
    add(BEQ,   1'b1, 4'd0,  C_FETCH_R, 4'd4);
    add(BEQ,   1'b1, 4'd1,  C_DEC,     4'd4);
    add(BEQ,   1'b1, 4'd8,  C_BRANCH,  4'd4);
    add(JMP,   1'b1, 4'd0,  C_FETCH_R, 4'd5);
    add(JMP,   1'b1, 4'd1,  C_DEC,     4'd5);
    add(JMP,   1'b1, 4'd9,  C_JUMP,    4'd5);
    add(SW,    1'b1, 4'd0,  C_FETCH_R, 4'd6);
    add(SW,    1'b1, 4'd1,  C_DEC,     4'd6);
    add(SW,    1'b1, 4'd2,  C_MADDR,   4'd6);
    add(SW,    1'b1, 4'd5,  C_MWR,     4'd6);

    rst_n = 1'b0;
    op = LW;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset ctrl", 32'(ctrl_w), 32'(C_ZERO));
    check("reset cnt", 32'(instr_cnt), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i].op, vecs[i].mr, vecs[i].st, vecs[i].ctrl, vecs[i].cnt, $sformatf("vec%0d", i));

    // Reset asserted while a load is stalled in MEM_RD
    step(LW, 1'b1, 4'd0, C_FETCH_R, 4'd7, "pre-rst fetch");
    step(LW, 1'b0, 4'd1, C_DEC,     4'd7, "pre-rst decode");
    step(LW, 1'b0, 4'd2, C_MADDR,   4'd7, "pre-rst maddr");
    step(LW, 1'b0, 4'd3, C_MRD,     4'd7, "pre-rst memrd");
    rst_n = 1'b0;
    step(LW, 1'b1, 4'd0, C_ZERO, 4'd0, "in-rst a");
    step(LW, 1'b1, 4'd0, C_ZERO, 4'd0, "in-rst b");
    rst_n = 1'b1;
    step(LW, 1'b1, 4'd0, C_FETCH_R, 4'd0, "post-rst fetch");

    // Illegal opcode: single-cycle flag, back to FETCH, nothing retired
    step(BAD, 1'b1, 4'd1, C_DEC_ILL, 4'd0, "illegal decode");

    // Fetch stall of three cycles
    pcwr_seen = 0;
    for (int i = 0; i < 3; i++) step(BAD, 1'b0, 4'd0, C_FETCH_W, 4'd0, $sformatf("stall%0d", i));
    step(SW, 1'b1, 4'd0, C_FETCH_R, 4'd0, "stall done");
    check("stall pcwr pulses", 32'(pcwr_seen), 32'd1);

    // Store with memory busy for two cycles
    memwr_seen = 0;
    regwr_seen = 0;
    step(SW, 1'b0, 4'd1, C_DEC,   4'd0, "sw decode");
    step(SW, 1'b0, 4'd2, C_MADDR, 4'd0, "sw maddr");
    step(SW, 1'b0, 4'd5, C_MWR,   4'd0, "sw wait0");
    step(SW, 1'b0, 4'd5, C_MWR,   4'd0, "sw wait1");
    step(SW, 1'b1, 4'd5, C_MWR,   4'd0, "sw done");
    check("sw memwr cycles", 32'(memwr_seen), 32'd3);
    check("sw regwr cycles", 32'(regwr_seen), 32'd0);

    // Run jumps up to an all-ones counter, then one more retire wraps to zero
    for (int i = 0; i < 15; i++) begin
      step(JMP, 1'b1, 4'd0, C_FETCH_R, CW'(1 + i), $sformatf("j%0d fetch", i));
      step(JMP, 1'b1, 4'd1, C_DEC,     CW'(1 + i), $sformatf("j%0d decode", i));
      step(JMP, 1'b1, 4'd9, C_JUMP,    CW'(1 + i), $sformatf("j%0d jump", i));
    end
    step(JMP, 1'b0, 4'd0, C_FETCH_W, 4'd0, "wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
